// File: rtl/rtc_field_bank_vga.sv
// rtc_field_bank_vga
//   Register bank for the BCD time/date/timer fields shown on the VGA clock.
//   Field index 0..8: seg, min, hora, dia, mes, year, t_seg, t_min, t_hora.
//   Fields load from the RTC read sequencer (seleccion=0) or from the user
//   edit path (seleccion=1, BCD inc/dec with per-field wrap limits). A commit
//   streams every field to the RTC write sequencer over a req/ack handshake.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   seleccion         0 = RTC read path, 1 = user edit path
//   rd_valid/rd_addr/rd_data   field load from the RTC read sequencer
//   edit_field, inc, dec       field under the cursor and edit pulses
//   commit            starts write-back (edit path only)
//   wr_ack            write sequencer accepted the current word
//   frame_sync        VGA vsync; only used when SHADOW_EN is defined
//   wr_req/wr_addr/wr_data     write-back word
//   busy              write-back in progress (bank frozen)
//   done              one-cycle pulse when write-back completes
//   field_bus         display values, field i at [8i+7:8i]
//
// Build option
//   SHADOW_EN: field_bus is a shadow copy refreshed on frame_sync, so the
//   display never changes mid-frame. Undefined: field_bus is the bank itself.

module rtc_field_bank_vga #(
    parameter int unsigned NUM_FIELDS = 9,
    parameter int unsigned ADDR_W     = 4,
    parameter logic [NUM_FIELDS*8-1:0] MAX_BCD =
        {8'h23, 8'h59, 8'h59, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59},
    parameter logic [NUM_FIELDS*8-1:0] MIN_BCD =
        {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    seleccion,
    input  logic                    rd_valid,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [7:0]              rd_data,
    input  logic [ADDR_W-1:0]       edit_field,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    commit,
    input  logic                    wr_ack,
    input  logic                    frame_sync,
    output logic                    wr_req,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [7:0]              wr_data,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_FIELDS*8-1:0] field_bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_FIELDS - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              sending;

    logic [7:0] bank_q [NUM_FIELDS];
    logic [7:0] bank_d [NUM_FIELDS];
    logic [NUM_FIELDS*8-1:0] bank_flat;

    // Out-of-range values (from an RTC load) are treated like the wrap case.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v >= hi || v < lo)
            return lo;
        if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        return {v[7:4], v[3:0] + 4'h1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v <= lo || v > hi)
            return hi;
        if (v[3:0] == 4'h0)
            return {v[7:4] - 4'h1, 4'h9};
        return {v[7:4], v[3:0] - 4'h1};
    endfunction

    assign sending = (state_q == SEND);

    // Field update. Addresses >= NUM_FIELDS match no field and are dropped.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            bank_d[i] = bank_q[i];
            if (!sending) begin
                if (!seleccion) begin
                    if (rd_valid && rd_addr == ADDR_W'(i))
                        bank_d[i] = rd_data;
                end else if (edit_field == ADDR_W'(i)) begin
                    if (inc && !dec)
                        bank_d[i] = bcd_inc(bank_q[i], MIN_BCD[8*i +: 8], MAX_BCD[8*i +: 8]);
                    else if (dec && !inc)
                        bank_d[i] = bcd_dec(bank_q[i], MIN_BCD[8*i +: 8], MAX_BCD[8*i +: 8]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_FIELDS; i++)
                bank_q[i] <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

    always_comb begin
        bank_flat = '0;
        for (int unsigned i = 0; i < NUM_FIELDS; i++)
            bank_flat[8*i +: 8] = bank_q[i];
    end

`ifdef SHADOW_EN
    logic [NUM_FIELDS*8-1:0] shadow_q;

    always_ff @(posedge clk) begin
        if (reset)
            shadow_q <= '0;
        else if (frame_sync)
            shadow_q <= bank_flat;
    end

    assign field_bus = shadow_q;
`else
    logic unused_frame_sync;
    assign unused_frame_sync = frame_sync;
    assign field_bus = bank_flat;
`endif

    // Write-back FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Write-back FSM: next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (commit && seleccion) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (wr_ack) begin
                    if (idx_q == LAST_IDX)
                        state_d = DONE;
                    else
                        idx_d = idx_q + ADDR_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write-back FSM: outputs, decoded from registers only
    always_comb begin
        wr_req  = sending;
        busy    = sending;
        done    = (state_q == DONE);
        wr_addr = sending ? idx_q : '0;
        wr_data = '0;
        if (sending) begin
            for (int unsigned i = 0; i < NUM_FIELDS; i++)
                if (idx_q == ADDR_W'(i))
                    wr_data = bank_q[i];
        end
    end

endmodule
